// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encoding,
// control bundle layout and the register-match helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    FLUSH  = 2'd2,
    MWAIT  = 2'd3
  } state_e;

  localparam int         CNT_W_DEF = 16;
  localparam logic [4:0] REG_ZERO  = 5'd0;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_we;
    logic exmem_flush;
    logic memwb_we;
  } ctl_t;

  localparam ctl_t CTL_RUN = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                               idex_we: 1'b1, idex_flush: 1'b0, exmem_we: 1'b1,
                               exmem_flush: 1'b0, memwb_we: 1'b1};

  // x0 is hardwired to zero, so a producer targeting it never creates a dependency.
  function automatic logic reads_reg(input logic [4:0] dst, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (dst != REG_ZERO) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 q <= '0;
    else if (clr)               q <= '0;
    else if (inc && (q != '1))  q <= q + W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: data hazards,
// MEM-resolved branches, memory wait states, perf counters and timeout flag.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FORWARDING  = 1,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_dst,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_dst,
  input  logic             mem_reg_write,
  input  logic             mem_branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             exmem_flush,
  output logic             memwb_we,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             mem_timeout
);

  localparam int             TW      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_MAX = TW'(MEM_TIMEOUT);

  state_e        st, st_nxt;
  ctl_t          ctl, ctl_out;
  logic          freeze, hazard, haz_load, haz_raw;
  logic          stall_inc, flush_inc, wait_inc;
  logic [TW-1:0] tmo_cnt;
  logic          mt;

  assign freeze   = dmem_req && !dmem_ready;
  assign haz_load = ex_mem_read && reads_reg(ex_dst, id_rs, id_rt, id_uses_rt);
  assign haz_raw  = (ex_reg_write  && reads_reg(ex_dst,  id_rs, id_rt, id_uses_rt)) ||
                    (mem_reg_write && reads_reg(mem_dst, id_rs, id_rt, id_uses_rt));
  assign hazard   = (FORWARDING != 0) ? haz_load : haz_raw;

  always_comb begin
    ctl       = CTL_RUN;
    st_nxt    = RUN;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    wait_inc  = 1'b0;
    if (freeze) begin
      ctl      = '0;
      st_nxt   = MWAIT;
      wait_inc = 1'b1;
    end else if (mem_branch_taken) begin
      ctl.ifid_flush  = 1'b1;
      ctl.idex_flush  = 1'b1;
      ctl.exmem_flush = 1'b1;
      st_nxt          = FLUSH;
      flush_inc       = 1'b1;
    end else if (hazard) begin
      ctl.pc_we      = 1'b0;
      ctl.ifid_we    = 1'b0;
      ctl.idex_flush = 1'b1;
      st_nxt         = DSTALL;
      stall_inc      = 1'b1;
    end else if (!imem_ready) begin
      // IF/ID still loads, but it loads a bubble while the fetch is pending
      ctl.pc_we      = 1'b0;
      ctl.ifid_flush = 1'b1;
      wait_inc       = 1'b1;
    end
  end

  // While reset is held the pipeline sees the plain RUN controls, never a flush.
  assign ctl_out     = rst_n ? ctl : CTL_RUN;
  assign pc_we       = ctl_out.pc_we;
  assign ifid_we     = ctl_out.ifid_we;
  assign ifid_flush  = ctl_out.ifid_flush;
  assign idex_we     = ctl_out.idex_we;
  assign idex_flush  = ctl_out.idex_flush;
  assign exmem_we    = ctl_out.exmem_we;
  assign exmem_flush = ctl_out.exmem_flush;
  assign memwb_we    = ctl_out.memwb_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= RUN;
    else        st <= st_nxt;
  end

  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      mt      <= 1'b0;
    end else begin
      if (!freeze)                tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);
      if (cnt_clr)                                         mt <= 1'b0;
      else if (freeze && (tmo_cnt >= TMO_MAX - TW'(1)))    mt <= 1'b1;
    end
  end

  assign mem_timeout = mt;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(stall_inc), .q(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(flush_inc), .q(flush_cnt));
  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(wait_inc), .q(wait_cnt));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: table vectors, directed corner sequences and
// random traffic against a priority-rule model, on two parameter sets.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
  logic id_uses_rt, ex_reg_write, ex_mem_read, mem_reg_write;
  logic mem_branch_taken, imem_ready, dmem_req, dmem_ready, cnt_clr;

  wire [7:0]  ctl_a, ctl_b;
  wire [1:0]  state_a, state_b;
  wire [3:0]  stall_a, flush_a, wait_a;
  wire [15:0] stall_b, flush_b, wait_b;
  wire        mt_a, mt_b;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FORWARDING(1), .CNT_W(4), .MEM_TIMEOUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_dst(mem_dst), .mem_reg_write(mem_reg_write), .mem_branch_taken(mem_branch_taken),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_we(ctl_a[7]), .ifid_we(ctl_a[6]), .ifid_flush(ctl_a[5]), .idex_we(ctl_a[4]),
    .idex_flush(ctl_a[3]), .exmem_we(ctl_a[2]), .exmem_flush(ctl_a[1]), .memwb_we(ctl_a[0]),
    .state(state_a), .stall_cnt(stall_a), .flush_cnt(flush_a), .wait_cnt(wait_a),
    .mem_timeout(mt_a));

  pipe_hazard_ctrl #(.FORWARDING(0), .CNT_W(16), .MEM_TIMEOUT(255)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_dst(mem_dst), .mem_reg_write(mem_reg_write), .mem_branch_taken(mem_branch_taken),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_we(ctl_b[7]), .ifid_we(ctl_b[6]), .ifid_flush(ctl_b[5]), .idex_we(ctl_b[4]),
    .idex_flush(ctl_b[3]), .exmem_we(ctl_b[2]), .exmem_flush(ctl_b[1]), .memwb_we(ctl_b[0]),
    .state(state_b), .stall_cnt(stall_b), .flush_cnt(flush_b), .wait_cnt(wait_b),
    .mem_timeout(mt_b));

  // control byte: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, memwb_we}
  localparam logic [7:0] C_FRZ = 8'b0000_0000;
  localparam logic [7:0] C_BR  = 8'b1111_1111;
  localparam logic [7:0] C_HAZ = 8'b0001_1101;
  localparam logic [7:0] C_IMW = 8'b0111_0101;
  localparam logic [7:0] C_RUN = 8'b1101_0101;

  int nvec = 0, nerr = 0;
  int m_state[2], m_stall[2], m_flush[2], m_wait[2], m_run[2];
  bit m_mt[2];
  logic [7:0] s_ctl[2];
  int cmax[2] = '{15, 65535};
  int tmo[2]  = '{4, 255};

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit depends(input logic [4:0] dst);
    return dst != 0 && (dst == id_rs || (id_uses_rt && dst == id_rt));
  endfunction

  // 0 freeze, 1 branch, 2 data hazard, 3 fetch wait, 4 run
  function automatic int cause(input int i);
    bit haz;
    if (i == 0) haz = ex_mem_read && depends(ex_dst);
    else        haz = (ex_reg_write && depends(ex_dst)) || (mem_reg_write && depends(mem_dst));
    if (dmem_req && !dmem_ready) return 0;
    if (mem_branch_taken)        return 1;
    if (haz)                     return 2;
    if (!imem_ready)             return 3;
    return 4;
  endfunction

  function automatic logic [7:0] exp_ctl(input int c);
    case (c)
      0: return C_FRZ;
      1: return C_BR;
      2: return C_HAZ;
      3: return C_IMW;
      default: return C_RUN;
    endcase
  endfunction

  function automatic int exp_state(input int c);
    case (c)
      0: return 3;
      1: return 2;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_wait[i] = 0; m_run[i] = 0; m_mt[i] = 0;
    end
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_dst = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_dst = 0; mem_reg_write = 0; mem_branch_taken = 0; imem_ready = 1;
    dmem_req = 0; dmem_ready = 1; cnt_clr = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle: check combinational controls mid-cycle, advance the model on
  // the edge, check registered state just after it.
  task automatic step();
    int c[2];
    @(negedge clk);
    s_ctl[0] = ctl_a;
    s_ctl[1] = ctl_b;
    for (int i = 0; i < 2; i++) begin
      c[i] = cause(i);
      chk($sformatf("ctl[%0d]", i), int'(s_ctl[i]), int'(exp_ctl(c[i])));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (cnt_clr) begin
        m_stall[i] = 0; m_flush[i] = 0; m_wait[i] = 0; m_mt[i] = 0;
      end else begin
        m_stall[i] = sat(m_stall[i] + (c[i] == 2 ? 1 : 0), cmax[i]);
        m_flush[i] = sat(m_flush[i] + (c[i] == 1 ? 1 : 0), cmax[i]);
        m_wait[i]  = sat(m_wait[i] + ((c[i] == 0 || c[i] == 3) ? 1 : 0), cmax[i]);
        if (c[i] == 0 && m_run[i] + 1 >= tmo[i]) m_mt[i] = 1;
      end
      m_run[i]   = (c[i] == 0) ? m_run[i] + 1 : 0;
      m_state[i] = exp_state(c[i]);
    end
    #1;
    chk("state_a", int'(state_a), m_state[0]);
    chk("state_b", int'(state_b), m_state[1]);
    chk("stall_a", int'(stall_a), m_stall[0]);
    chk("stall_b", int'(stall_b), m_stall[1]);
    chk("flush_a", int'(flush_a), m_flush[0]);
    chk("flush_b", int'(flush_b), m_flush[1]);
    chk("wait_a",  int'(wait_a),  m_wait[0]);
    chk("wait_b",  int'(wait_b),  m_wait[1]);
    chk("mt_a",    int'(mt_a),    int'(m_mt[0]));
    chk("mt_b",    int'(mt_b),    int'(m_mt[1]));
  endtask

  typedef struct {
    logic [4:0] rs, rt; logic urt;
    logic [4:0] exd; logic exrw, exmr;
    logic [4:0] md; logic mrw, br, imr, dreq, drdy;
    logic [7:0] ca; int sa; logic [7:0] cb; int sb;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_RUN, 0, C_RUN, 0};
    tbl[1]  = '{5, 0, 0, 5, 1, 1, 0, 0, 0, 1, 0, 1, C_HAZ, 1, C_HAZ, 1};
    tbl[2]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, C_RUN, 0, C_RUN, 0};
    tbl[3]  = '{3, 7, 0, 7, 1, 1, 0, 0, 0, 1, 0, 1, C_RUN, 0, C_RUN, 0};
    tbl[4]  = '{3, 7, 1, 7, 1, 1, 0, 0, 0, 1, 0, 1, C_HAZ, 1, C_HAZ, 1};
    tbl[5]  = '{9, 0, 0, 0, 0, 0, 9, 1, 0, 1, 0, 1, C_RUN, 0, C_HAZ, 1};
    tbl[6]  = '{4, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 1, C_RUN, 0, C_HAZ, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_IMW, 0, C_IMW, 0};
    tbl[8]  = '{5, 0, 0, 5, 1, 1, 0, 0, 1, 1, 0, 1, C_BR,  2, C_BR,  2};
    tbl[9]  = '{5, 0, 0, 5, 1, 1, 0, 0, 1, 1, 1, 0, C_FRZ, 3, C_FRZ, 3};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_IMW, 0, C_IMW, 0};

    idle();
    #2;
    // reset state, with outputs forced to RUN controls while held
    chk("rst_state_a", int'(state_a), 0);
    chk("rst_ctl_a",   int'(ctl_a), int'(C_RUN));
    chk("rst_stall_b", int'(stall_b), 0);
    chk("rst_mt_a",    int'(mt_a), 0);
    @(posedge clk); #1;
    do_reset();

    foreach (tbl[k]) begin
      id_rs = tbl[k].rs; id_rt = tbl[k].rt; id_uses_rt = tbl[k].urt;
      ex_dst = tbl[k].exd; ex_reg_write = tbl[k].exrw; ex_mem_read = tbl[k].exmr;
      mem_dst = tbl[k].md; mem_reg_write = tbl[k].mrw; mem_branch_taken = tbl[k].br;
      imem_ready = tbl[k].imr; dmem_req = tbl[k].dreq; dmem_ready = tbl[k].drdy;
      step();
      chk($sformatf("tbl%0d_ctl_a", k), int'(s_ctl[0]), int'(tbl[k].ca));
      chk($sformatf("tbl%0d_ctl_b", k), int'(s_ctl[1]), int'(tbl[k].cb));
      chk($sformatf("tbl%0d_st_a", k),  int'(state_a), tbl[k].sa);
      chk($sformatf("tbl%0d_st_b", k),  int'(state_b), tbl[k].sb);
    end

    // load-use: one stall cycle, then the bubble clears it
    do_reset();
    ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5; id_rs = 5;
    step();
    chk("lu_pc_we", int'(s_ctl[0][7]), 0);
    chk("lu_ifid_we", int'(s_ctl[0][6]), 0);
    chk("lu_idex_flush", int'(s_ctl[0][3]), 1);
    chk("lu_state", int'(state_a), 1);
    chk("lu_stall", int'(stall_a), 1);
    idle();
    step();
    chk("lu_after_ctl", int'(s_ctl[0]), int'(C_RUN));
    chk("lu_after_state", int'(state_a), 0);
    chk("lu_after_stall", int'(stall_a), 1);

    // register 0 never stalls
    do_reset();
    ex_mem_read = 1; ex_dst = 0; id_rs = 0;
    step();
    chk("r0_stall", int'(stall_a), 0);
    chk("r0_state", int'(state_a), 0);

    // branch beats load-use
    do_reset();
    ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5; id_rs = 5; mem_branch_taken = 1;
    step();
    chk("br_ctl", int'(s_ctl[0]), int'(C_BR));
    chk("br_state", int'(state_a), 2);
    chk("br_flush", int'(flush_a), 1);
    chk("br_stall", int'(stall_a), 0);

    // dmem wait holds the branch back for 3 cycles
    do_reset();
    dmem_req = 1; dmem_ready = 0; mem_branch_taken = 1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("dw_ctl", int'(s_ctl[0]), int'(C_FRZ));
    end
    chk("dw_wait", int'(wait_a), 3);
    chk("dw_state", int'(state_a), 3);
    dmem_ready = 1;
    step();
    chk("dw_br_ctl", int'(s_ctl[0]), int'(C_BR));
    chk("dw_br_state", int'(state_a), 2);
    chk("dw_br_flush", int'(flush_a), 1);

    // timeout after 4 freeze cycles, sticky until cnt_clr
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int n = 0; n < 3; n++) step();
    chk("to_pre", int'(mt_a), 0);
    step();
    chk("to_set", int'(mt_a), 1);
    dmem_req = 0;
    step();
    chk("to_sticky", int'(mt_a), 1);
    cnt_clr = 1;
    step();
    chk("to_clr", int'(mt_a), 0);
    chk("to_clr_wait", int'(wait_a), 0);
    cnt_clr = 0;

    // 20 stalls saturate the 4-bit counter
    do_reset();
    ex_mem_read = 1; ex_reg_write = 1; ex_dst = 6; id_rt = 6; id_uses_rt = 1;
    for (int n = 0; n < 20; n++) step();
    chk("sat_stall_a", int'(stall_a), 15);
    chk("sat_stall_b", int'(stall_b), 20);

    // asynchronous reset in the middle of a freeze
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    step(); step();
    chk("ar_pre_state", int'(state_a), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", int'(state_a), 0);
    chk("ar_wait", int'(wait_a), 0);
    chk("ar_pc_we", int'(ctl_a[7]), 1);
    chk("ar_ctl", int'(ctl_a), int'(C_RUN));
    @(posedge clk); #1;
    do_reset();

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_dst = 5'($urandom_range(0, 3)); mem_dst = 5'($urandom_range(0, 3));
      ex_reg_write = 1'($urandom_range(0, 1)); ex_mem_read = 1'($urandom_range(0, 1));
      mem_reg_write = 1'($urandom_range(0, 1));
      mem_branch_taken = ($urandom_range(0, 5) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      dmem_req = ($urandom_range(0, 2) == 0);
      dmem_ready = 1'($urandom_range(0, 1));
      cnt_clr = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
